// File: rtl/tl_uncached_pkg.sv
// Shared widths, message encodings and lock state type for the uncached
// TileLink client-side arbiter.
package tl_uncached_pkg;
  localparam int ADDR_BLOCK_W = 26;
  localparam int BEAT_W       = 3;
  localparam int UNION_W      = 12;
  localparam int DATA_W       = 64;
  localparam int MGR_XID_W    = 2;
  localparam int G_TYPE_W     = 4;
  localparam int A_TYPE_W     = 3;
  localparam int BEATS        = 8;

  localparam logic [A_TYPE_W-1:0] A_PUT_BLOCK      = 3'b011;
  localparam logic [A_TYPE_W-1:0] A_GET_BLOCK      = 3'b001;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BLOCK = 4'b0101;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  function automatic logic is_multi_beat(input logic builtin,
                                         input logic [A_TYPE_W-1:0] a_type);
    return builtin && (a_type == A_PUT_BLOCK);
  endfunction
endpackage

// File: rtl/tl_rr_lock_ctrl.sv
// Round-robin select with burst lock and stall hold for two acquire clients.
// state       | meaning
// LOCK_IDLE   | free arbitration (hold, then round-robin on contention)
// LOCK_LOCKED | PutBlock in flight, owner keeps the port until the last beat
module tl_rr_lock_ctrl
  import tl_uncached_pkg::*;
#(
  parameter int BEATS_P = BEATS
) (
  input  logic clk,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  input  logic multi_0,
  input  logic multi_1,
  input  logic out_ready,
  output logic sel
);
  lock_state_t       state, state_nxt;
  logic              owner, owner_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              last, last_nxt;
  logic              hold_vld, hold_vld_nxt;
  logic              hold_sel, hold_sel_nxt;
  logic              out_valid, fire, sel_multi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOCK_IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
      last     <= 1'b1;
      hold_vld <= 1'b0;
      hold_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      last     <= last_nxt;
      hold_vld <= hold_vld_nxt;
      hold_sel <= hold_sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    last_nxt     = last;

    if (state == LOCK_LOCKED) sel = owner;
    else if (hold_vld)        sel = hold_sel;
    else if (req_0 && req_1)  sel = ~last;
    else                      sel = req_1;

    out_valid = sel ? req_1 : req_0;
    sel_multi = sel ? multi_1 : multi_0;
    fire      = out_valid && out_ready;
    // A stalled request pins the selection; dropping valid releases it.
    hold_vld_nxt = out_valid && !out_ready;
    hold_sel_nxt = sel;

    case (state)
      LOCK_IDLE: begin
        if (fire) begin
          if (sel_multi) begin
            state_nxt    = LOCK_LOCKED;
            owner_nxt    = sel;
            beat_cnt_nxt = BEAT_W'(1);
          end else begin
            last_nxt = sel;
          end
        end
      end
      LOCK_LOCKED: begin
        if (fire) begin
          if (beat_cnt == BEAT_W'(BEATS_P - 1)) begin
            state_nxt    = LOCK_IDLE;
            last_nxt     = owner;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          end
        end
      end
      default: state_nxt = LOCK_IDLE;
    endcase
  end
endmodule

// File: rtl/client_uncached_tile_link_rr_arbiter.sv
// Two-client uncached TileLink arbiter: acquire muxing with client-index id
// tagging, grant routing on the low id bit.
module client_uncached_tile_link_rr_arbiter
  import tl_uncached_pkg::*;
#(
  parameter int XID_W = 1,
  parameter int BEATS_P = BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    io_in_0_acquire_ready,
  input  logic                    io_in_0_acquire_valid,
  input  logic [ADDR_BLOCK_W-1:0] io_in_0_acquire_bits_addr_block,
  input  logic [XID_W-1:0]        io_in_0_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]       io_in_0_acquire_bits_addr_beat,
  input  logic                    io_in_0_acquire_bits_is_builtin_type,
  input  logic [A_TYPE_W-1:0]     io_in_0_acquire_bits_a_type,
  input  logic [UNION_W-1:0]      io_in_0_acquire_bits_union,
  input  logic [DATA_W-1:0]       io_in_0_acquire_bits_data,
  input  logic                    io_in_0_grant_ready,
  output logic                    io_in_0_grant_valid,
  output logic [BEAT_W-1:0]       io_in_0_grant_bits_addr_beat,
  output logic [XID_W-1:0]        io_in_0_grant_bits_client_xact_id,
  output logic [MGR_XID_W-1:0]    io_in_0_grant_bits_manager_xact_id,
  output logic                    io_in_0_grant_bits_is_builtin_type,
  output logic [G_TYPE_W-1:0]     io_in_0_grant_bits_g_type,
  output logic [DATA_W-1:0]       io_in_0_grant_bits_data,
  output logic                    io_in_1_acquire_ready,
  input  logic                    io_in_1_acquire_valid,
  input  logic [ADDR_BLOCK_W-1:0] io_in_1_acquire_bits_addr_block,
  input  logic [XID_W-1:0]        io_in_1_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]       io_in_1_acquire_bits_addr_beat,
  input  logic                    io_in_1_acquire_bits_is_builtin_type,
  input  logic [A_TYPE_W-1:0]     io_in_1_acquire_bits_a_type,
  input  logic [UNION_W-1:0]      io_in_1_acquire_bits_union,
  input  logic [DATA_W-1:0]       io_in_1_acquire_bits_data,
  input  logic                    io_in_1_grant_ready,
  output logic                    io_in_1_grant_valid,
  output logic [BEAT_W-1:0]       io_in_1_grant_bits_addr_beat,
  output logic [XID_W-1:0]        io_in_1_grant_bits_client_xact_id,
  output logic [MGR_XID_W-1:0]    io_in_1_grant_bits_manager_xact_id,
  output logic                    io_in_1_grant_bits_is_builtin_type,
  output logic [G_TYPE_W-1:0]     io_in_1_grant_bits_g_type,
  output logic [DATA_W-1:0]       io_in_1_grant_bits_data,
  input  logic                    io_out_acquire_ready,
  output logic                    io_out_acquire_valid,
  output logic [ADDR_BLOCK_W-1:0] io_out_acquire_bits_addr_block,
  output logic [XID_W:0]          io_out_acquire_bits_client_xact_id,
  output logic [BEAT_W-1:0]       io_out_acquire_bits_addr_beat,
  output logic                    io_out_acquire_bits_is_builtin_type,
  output logic [A_TYPE_W-1:0]     io_out_acquire_bits_a_type,
  output logic [UNION_W-1:0]      io_out_acquire_bits_union,
  output logic [DATA_W-1:0]       io_out_acquire_bits_data,
  output logic                    io_out_grant_ready,
  input  logic                    io_out_grant_valid,
  input  logic [BEAT_W-1:0]       io_out_grant_bits_addr_beat,
  input  logic [XID_W:0]          io_out_grant_bits_client_xact_id,
  input  logic [MGR_XID_W-1:0]    io_out_grant_bits_manager_xact_id,
  input  logic                    io_out_grant_bits_is_builtin_type,
  input  logic [G_TYPE_W-1:0]     io_out_grant_bits_g_type,
  input  logic [DATA_W-1:0]       io_out_grant_bits_data
);
  logic sel, msel, route;

  tl_rr_lock_ctrl #(.BEATS_P(BEATS_P)) u_lock_ctrl (
    .clk       (clk),
    .reset     (reset),
    .req_0     (io_in_0_acquire_valid),
    .req_1     (io_in_1_acquire_valid),
    .multi_0   (is_multi_beat(io_in_0_acquire_bits_is_builtin_type, io_in_0_acquire_bits_a_type)),
    .multi_1   (is_multi_beat(io_in_1_acquire_bits_is_builtin_type, io_in_1_acquire_bits_a_type)),
    .out_ready (io_out_acquire_ready),
    .sel       (sel)
  );

  // In reset every handshake is suppressed and the bit muxes park on client 0.
  assign msel = reset && sel;

  assign io_out_acquire_valid  = reset && (msel ? io_in_1_acquire_valid : io_in_0_acquire_valid);
  assign io_in_0_acquire_ready = reset && !msel && io_out_acquire_ready;
  assign io_in_1_acquire_ready = msel && io_out_acquire_ready;

  assign io_out_acquire_bits_addr_block      = msel ? io_in_1_acquire_bits_addr_block : io_in_0_acquire_bits_addr_block;
  assign io_out_acquire_bits_client_xact_id  = msel ? {io_in_1_acquire_bits_client_xact_id, 1'b1}
                                                    : {io_in_0_acquire_bits_client_xact_id, 1'b0};
  assign io_out_acquire_bits_addr_beat       = msel ? io_in_1_acquire_bits_addr_beat : io_in_0_acquire_bits_addr_beat;
  assign io_out_acquire_bits_is_builtin_type = msel ? io_in_1_acquire_bits_is_builtin_type : io_in_0_acquire_bits_is_builtin_type;
  assign io_out_acquire_bits_a_type          = msel ? io_in_1_acquire_bits_a_type : io_in_0_acquire_bits_a_type;
  assign io_out_acquire_bits_union           = msel ? io_in_1_acquire_bits_union : io_in_0_acquire_bits_union;
  assign io_out_acquire_bits_data            = msel ? io_in_1_acquire_bits_data : io_in_0_acquire_bits_data;

  assign route               = io_out_grant_bits_client_xact_id[0];
  assign io_in_0_grant_valid = reset && io_out_grant_valid && !route;
  assign io_in_1_grant_valid = reset && io_out_grant_valid && route;
  assign io_out_grant_ready  = reset && (route ? io_in_1_grant_ready : io_in_0_grant_ready);

  assign io_in_0_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
  assign io_in_0_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[XID_W:1];
  assign io_in_0_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
  assign io_in_0_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
  assign io_in_0_grant_bits_g_type          = io_out_grant_bits_g_type;
  assign io_in_0_grant_bits_data            = io_out_grant_bits_data;
  assign io_in_1_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
  assign io_in_1_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[XID_W:1];
  assign io_in_1_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
  assign io_in_1_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
  assign io_in_1_grant_bits_g_type          = io_out_grant_bits_g_type;
  assign io_in_1_grant_bits_data            = io_out_grant_bits_data;
endmodule

// File: doc/client_uncached_tile_link_rr_arbiter.md
Name: client_uncached_tile_link_rr_arbiter

Overview:
Two-client round-robin arbiter for the uncached TileLink client port. It sits between two uncached TileLink masters (core I-side and D-side) and the single uncached TileLink port feeding the TileLink-to-AXI4 converter.
- Acquire: arbitrated with a burst lock, so a multi-beat PutBlock is never interleaved with another client's traffic.
- Grant: routed back by a client-index bit appended to client_xact_id.

Parameters:
XID_W, 1, per-client client_xact_id width; manager-side id is XID_W+1.
BEATS, 8, beats per block transfer; addr_beat width is 3.

Ports:
clk  input  1  core clock.
reset  input  1  asynchronous, active-low (0 = in reset).
io_in_<i>_acquire_ready  output  1  (i = 0,1) acquire accepted from client i.
io_in_<i>_acquire_valid  input  1  client i acquire request.
io_in_<i>_acquire_bits_{addr_block,client_xact_id,addr_beat,is_builtin_type,a_type,union,data}  input  26/XID_W/3/1/3/12/64  client i acquire fields.
io_in_<i>_grant_ready  input  1  client i can take a grant.
io_in_<i>_grant_valid  output  1  grant for client i.
io_in_<i>_grant_bits_{addr_beat,client_xact_id,manager_xact_id,is_builtin_type,g_type,data}  output  3/XID_W/2/1/4/64  grant fields.
io_out_acquire_ready  input  1  manager accepts acquire.
io_out_acquire_valid  output  1  arbitrated acquire valid.
io_out_acquire_bits_{addr_block,client_xact_id,addr_beat,is_builtin_type,a_type,union,data}  output  26/XID_W+1/3/1/3/12/64  selected client's fields; client_xact_id = {in_id, i}.
io_out_grant_ready  output  1  ready of the addressed client.
io_out_grant_valid  input  1  manager grant valid.
io_out_grant_bits_{addr_beat,client_xact_id,manager_xact_id,is_builtin_type,g_type,data}  input  3/XID_W+1/2/1/4/64  grant fields.

Behaviour:
- State registers (async clear on reset=0):
  - lock: IDLE / LOCKED.
  - owner: 1 bit.
  - beat_cnt: 3 bits.
  - last: 1 bit, reset value 1, so client 0 wins first.
  - hold_vld / hold_sel: 1 bit each.
- Outputs during reset=0: all valid and ready outputs are forced to 0. Data and bits outputs are don't-care, driven from client 0's mux path.
- Latency: zero-cycle combinational datapath in both directions. No data is stored.
- Selection in IDLE:
  - If hold_vld=1: sel = hold_sel.
  - Else if both clients are valid: sel = ~last.
  - Else: sel = the valid client.
- Selection in LOCKED: sel = owner. The other client's acquire_ready is 0.
- Request hold: hold_vld is set when io_out_acquire_valid=1 and ready=0, with hold_sel = sel. It clears on fire. A request presented but not yet accepted never switches client.
- Handshakes:
  - io_out_acquire_valid = in_sel valid.
  - io_in_sel acquire_ready = io_out_acquire_ready. The non-selected client's ready is 0.
  - fire = out valid & ready.
- Multi-beat detection: is_builtin_type=1 and a_type=3'b011 (PutBlock).
- Transitions:
  - IDLE, fire of a multi-beat acquire → LOCKED; owner = sel; beat_cnt = 1.
  - IDLE, fire of a single-beat acquire → stay IDLE; last = sel.
  - LOCKED, fire with beat_cnt = BEATS-1 → IDLE; last = owner; beat_cnt = 0.
  - LOCKED, other fire → beat_cnt + 1.
  - beat_cnt counts by handshake, not by addr_beat value.
- Grant routing:
  - Route index r = io_out_grant_bits_client_xact_id[0].
  - io_in_r grant_valid = io_out_grant_valid; the other client's grant_valid is 0.
  - io_out_grant_ready = io_in_r grant_ready.
  - Forwarded client_xact_id = upper XID_W bits. All other grant fields pass through unchanged.
  - No grant state: acquire and grant channels run concurrently and independently.
- Simultaneous events: a grant to one client in the same cycle as an acquire fire from the other is legal. Both complete.
- Reset mid-burst: lock returns to IDLE, beat_cnt = 0, last = 1, hold cleared. Any partial burst is abandoned; the system resets the manager side with it.

Decomposition:
- Package tl_uncached_pkg:
  - Widths: ADDR_BLOCK_W=26, BEAT_W=3, UNION_W=12, DATA_W=64, MGR_XID_W=2, G_TYPE_W=4.
  - Constants: BEATS, A_PUT_BLOCK=3'b011, A_GET_BLOCK=3'b001, G_GET_DATA_BLOCK=4'b0101.
  - Typedef lock_state_t.
- Sub-module tl_rr_lock_ctrl: holds lock, owner, beat_cnt, last and hold state, and produces sel and the lock status. The top level contains only muxes and id tagging.

Test Plan:
1. Both clients present a single-beat Get, out_ready=1 → client 0 fires with out id {id0,0}. Next cycle client 1 fires with {id1,1}. Alternation continues while both stay valid.
2. Client 0 sends PutBlock (8 beats) while client 1 is continuously valid → 8 consecutive client-0 beats. in_1 acquire_ready stays 0 throughout. Client 1 fires on the 9th handshake.
3. Stall: out_ready=0 for 3 cycles while client 0 is selected, and client 1 raises valid mid-stall → output stays on client 0 until it fires.
4. Grant with client_xact_id=2'b11, g_type=5, data=0xDEADBEEF → only in_1 grant_valid=1, with id=1 and data=0xDEADBEEF. out grant_ready follows in_1 grant_ready.
5. Assert reset=0 after beat 4 of a client-1 PutBlock → all valid and ready outputs are 0 immediately. After release, client 0 wins the first contention.
